// File: rtl/kws_pkg.sv
// Shared types and constants for the keyword-spotting datapath stages.
// The saturating adder in this package's users honours the MAC_ACC_SAT_EN build macro.
package kws_pkg;

  localparam int ACC_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturation limits for the default accumulator width
  localparam logic [ACC_W_DEFAULT-1:0] ACC_MAX = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
  localparam logic [ACC_W_DEFAULT-1:0] ACC_MIN = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/kws_sat_add.sv
// Combinational two's-complement adder with optional saturation.
// Build macro MAC_ACC_SAT_EN: defined -> clamp on overflow and flag it; undefined -> wrap, ovf=0.
module kws_sat_add
  import kws_pkg::*;
#(
  parameter int W = ACC_W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;

`ifdef MAC_ACC_SAT_EN
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic overflow;

  // Overflow only possible when both operands share a sign the result lacks
  assign overflow = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  assign sum      = overflow ? (a[W-1] ? MIN_VAL : MAX_VAL) : raw;
  assign ovf      = overflow;
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Streaming signed dot-product onto a bias; one ACC_W result per start, feeding the ReLU stage.
// Build macro MAC_ACC_SAT_EN selects saturating accumulation with a sticky ovf flag.
module mac_accumulator
  import kws_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ACC_W-1:0]  cfg_bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [ACC_W-1:0]  data_out,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;

  state_t state;
  state_t state_next;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  add_sum;
  logic [ACC_W-1:0]  prod_ext;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_q;
  logic              prod_valid;
  logic              add_ovf;
  logic              accept_start;
  logic              handshake;

  // Sign-extend before multiplying so the low PROD_W bits are the exact signed product
  assign a_ext    = {{DATA_W{in_a[DATA_W-1]}}, in_a};
  assign b_ext    = {{DATA_W{in_b[DATA_W-1]}}, in_b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_W'($signed(prod_q));

  kws_sat_add #(
    .W(ACC_W)
  ) u_add (
    .a  (acc),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    accept_start = 1'b0;
    handshake    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept_start = 1'b1;
          state_next   = (cfg_len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        in_ready  = (count != len_q);
        handshake = in_valid && in_ready;
        if (handshake && ((count + LEN_W'(1)) == len_q)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Multiply stage registers the product; the accumulate stage folds it in one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      count      <= '0;
      acc        <= '0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
      ovf        <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_start) begin
        len_q      <= cfg_len;
        acc        <= cfg_bias;
        count      <= '0;
        ovf        <= 1'b0;
        prod_valid <= 1'b0;
      end else begin
        if (prod_valid) begin
          acc <= add_sum;
          if (add_ovf) begin
            ovf <= 1'b1;
          end
        end
        prod_valid <= handshake;
        if (handshake) begin
          prod_q <= prod;
          count  <= count + LEN_W'(1);
        end
      end
      if (state == DONE) begin
        data_out <= acc;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: scoreboard of expected results, per-scenario tasks.
// Honours MAC_ACC_SAT_EN to pick saturating or wrapping expectations.
module tb_mac_accumulator;
  import kws_pkg::*;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 64;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [ACC_W-1:0]  cfg_bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [ACC_W-1:0]  data_out;
  logic              done;
  logic              busy;
  logic              ovf;

  typedef struct packed {
    logic [63:0] data;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pa[16];
  int   pb[16];

  int   hs_cnt;
  int   ready_cnt;
  int   blocked_cnt;
  int   latency;
  int   start_cyc;
  int   done_cyc;
  logic timed_out;

  mac_accumulator #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cfg_len (cfg_len),
    .cfg_bias(cfg_bias),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .data_out(data_out),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sequential adds in 65-bit arithmetic, clamped when the extra bit disagrees
  function automatic exp_t model(input logic [15:0] len, input logic [63:0] bias);
    logic [64:0] w;
    logic [63:0] acc;
    logic [63:0] prod;
    exp_t        e;
    acc   = bias;
    e.ovf = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      prod = longint'(pa[i]) * longint'(pb[i]);
      w    = {acc[63], acc} + {prod[63], prod};
`ifdef MAC_ACC_SAT_EN
      if (w[64] != w[63]) begin
        acc   = w[64] ? ACC_MIN : ACC_MAX;
        e.ovf = 1'b1;
      end else begin
        acc = w[63:0];
      end
`else
      acc = w[63:0];
`endif
    end
    e.data = acc;
    return e;
  endfunction

  // Starts a job at the current negedge and streams pa/pb per vpat; returns at the done negedge
  task automatic run_job(input logic [15:0] len, input logic [63:0] bias, input int n_pat,
                         input logic [31:0] vpat, input int glitch_at);
    int idx;
    int pi;
    int last_hs;
    hs_cnt      = 0;
    ready_cnt   = 0;
    blocked_cnt = 0;
    timed_out   = 1'b1;
    done_cyc    = -1;
    start       = 1'b1;
    cfg_len     = len;
    cfg_bias    = bias;
    in_valid    = 1'b0;
    exp_q.push_back(model(len, bias));
    start_cyc = cyc;
    last_hs   = cyc;
    idx       = 0;
    pi        = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = (k == glitch_at);
      if (start) begin
        cfg_len  = 16'd1;
        cfg_bias = 64'd999;
      end
      if (done === 1'b1) begin
        timed_out = 1'b0;
        done_cyc  = cyc;
        break;
      end
      in_valid = (pi < n_pat) ? vpat[pi] : 1'b0;
      pi++;
      in_a = 16'(pa[idx & 15]);
      in_b = 16'(pb[idx & 15]);
      if (in_ready === 1'b1) ready_cnt++;
      if (in_valid && in_ready === 1'b1) begin
        hs_cnt++;
        idx++;
        last_hs = cyc;
      end else if (in_valid && hs_cnt == int'(len)) begin
        blocked_cnt++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    latency  = done_cyc - last_hs;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    cfg_len  = '0;
    cfg_bias = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_out !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_data_out got %0h want 0", data_out); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t        e;
    logic [63:0] held;
    pa[0] = 1;  pb[0] = 2;
    pa[1] = 3;  pb[1] = 4;
    pa[2] = -5; pb[2] = 6;
    pa[3] = 7;  pb[3] = -1;
    run_job(16'd4, 64'd10, 4, 32'hF, -1);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_timeout got %b want 0", timed_out); end
    n_checks++;
    if (hs_cnt != 4) begin n_fail++; $display("[TB] FAIL basic_handshakes got %0d want 4", hs_cnt); end
    n_checks++;
    if (ready_cnt != 4) begin n_fail++; $display("[TB] FAIL basic_ready_cycles got %0d want 4", ready_cnt); end
    n_checks++;
    if (latency != 3) begin n_fail++; $display("[TB] FAIL basic_latency got %0d want 3", latency); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_at_done got %b want 0", busy); end
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL basic_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    n_checks++;
    if (ovf !== e.ovf) begin n_fail++; $display("[TB] FAIL basic_ovf got %b want %b", ovf, e.ovf); end
    held = e.data;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_width got %b want 0", done); end
    n_checks++;
    if (data_out !== held) begin
      n_fail++; $display("[TB] FAIL basic_data_hold got %0d want %0d", $signed(data_out), $signed(held));
    end
  endtask

  task automatic test_zero_len();
    exp_t e;
    run_job(16'd0, -64'sd5, 0, 32'h0, -1);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_timeout got %b want 0", timed_out); end
    n_checks++;
    if (latency != 2) begin n_fail++; $display("[TB] FAIL zero_latency got %0d want 2", latency); end
    n_checks++;
    if (ready_cnt != 0) begin n_fail++; $display("[TB] FAIL zero_ready_cycles got %0d want 0", ready_cnt); end
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL zero_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    exp_t e;
    pa[0] = 2;   pb[0] = 5;
    pa[1] = -3;  pb[1] = 6;
    pa[2] = 4;   pb[2] = -7;
    pa[3] = 100; pb[3] = 100;
    pa[4] = 100; pb[4] = 100;
    run_job(16'd3, 64'd1000, 8, 32'b1110_1001, -1);
    n_checks++;
    if (hs_cnt != 3) begin n_fail++; $display("[TB] FAIL gaps_handshakes got %0d want 3", hs_cnt); end
    n_checks++;
    if (blocked_cnt != 2) begin n_fail++; $display("[TB] FAIL gaps_extra_blocked got %0d want 2", blocked_cnt); end
    n_checks++;
    if (latency != 3) begin n_fail++; $display("[TB] FAIL gaps_latency got %0d want 3", latency); end
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL gaps_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   hs;
    int   done_seen;
    hs        = 0;
    done_seen = 0;
    start     = 1'b1;
    cfg_len   = 16'd5;
    cfg_bias  = 64'd77;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 16'd9;
    in_b     = 16'd9;
    for (int k = 0; k < 10 && hs < 2; k++) begin
      if (in_ready === 1'b1) hs++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hs != 2) begin n_fail++; $display("[TB] FAIL abort_handshakes got %0d want 2", hs); end
    n_checks++;
    if ({data_out, done, busy, in_ready, ovf} !== '0) begin
      n_fail++; $display("[TB] FAIL abort_outputs got data=%0h done=%b busy=%b rdy=%b ovf=%b want all 0",
                         data_out, done, busy, in_ready, ovf);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin n_fail++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", done_seen); end
    pa[0] = 1; pb[0] = 1;
    run_job(16'd1, 64'd0, 1, 32'h1, -1);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL abort_fresh_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    pa[0] = 3; pb[0] = 2;
    pa[1] = 4; pb[1] = -2;
    pa[2] = 5; pb[2] = 10;
    run_job(16'd3, 64'd100, 3, 32'h7, 1);
    n_checks++;
    if (hs_cnt != 3) begin n_fail++; $display("[TB] FAIL ignored_handshakes got %0d want 3", hs_cnt); end
    n_checks++;
    if (latency != 3) begin n_fail++; $display("[TB] FAIL ignored_latency got %0d want 3", latency); end
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL ignored_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    pa[0] = 4; pb[0] = 6;
    pa[1] = 5; pb[1] = 7;
    run_job(16'd2, 64'd0, 2, 32'h3, -1);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL b2b_first_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    pa[0] = -2; pb[0] = 3;
    pa[1] = 0;  pb[1] = 9;
    run_job(16'd2, 64'd1, 2, 32'h3, -1);
    n_checks++;
    if (done_cyc - start_cyc != 5) begin
      n_fail++; $display("[TB] FAIL b2b_start_to_done got %0d want 5", done_cyc - start_cyc);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin
      n_fail++; $display("[TB] FAIL b2b_second_data got %0d want %0d", $signed(data_out), $signed(e.data));
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    exp_t        e;
    logic [63:0] want_data;
    logic        want_ovf;
    pa[0] = 1; pb[0] = 1;
    run_job(16'd1, ACC_MAX, 1, 32'h1, -1);
`ifdef MAC_ACC_SAT_EN
    want_data = ACC_MAX;
    want_ovf  = 1'b1;
`else
    want_data = ACC_MIN;
    want_ovf  = 1'b0;
`endif
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin n_fail++; $display("[TB] FAIL satpos_sb_data got %0h want %0h", data_out, e.data); end
    n_checks++;
    if (data_out !== want_data) begin n_fail++; $display("[TB] FAIL satpos_data got %0h want %0h", data_out, want_data); end
    n_checks++;
    if (ovf !== want_ovf) begin n_fail++; $display("[TB] FAIL satpos_ovf got %b want %b", ovf, want_ovf); end
    @(negedge clk);
    n_checks++;
    if (ovf !== want_ovf) begin n_fail++; $display("[TB] FAIL satpos_ovf_sticky got %b want %b", ovf, want_ovf); end
    pa[0] = -1; pb[0] = 1;
    run_job(16'd1, ACC_MIN, 1, 32'h1, -1);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e.data) begin n_fail++; $display("[TB] FAIL satneg_data got %0h want %0h", data_out, e.data); end
    n_checks++;
    if (ovf !== e.ovf) begin n_fail++; $display("[TB] FAIL satneg_ovf got %b want %b", ovf, e.ovf); end
    @(negedge clk);
    pa[0] = 2; pb[0] = 3;
    run_job(16'd1, 64'd0, 1, 32'h1, -1);
    e = exp_q.pop_front();
    n_checks++;
    if (ovf !== 1'b0 || e.ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_cleared got %b want 0", ovf); end
    n_checks++;
    if (data_out !== 64'd6) begin n_fail++; $display("[TB] FAIL ovf_cleared_data got %0d want 6", $signed(data_out)); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
